// File: rtl/glitch_sequencer.sv
// Glitch timing engine: snapshots delay/width/count/spacing at launch and plays the pulse train on glitch_o.
// Optional macro GLITCH_TRIGGER_SYNC_EN adds a 2-flop synchronizer in front of the trigger edge detector.
module glitch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] delay_i,
    input  logic [7:0]  width_i,
    input  logic [7:0]  num_pulses_i,
    input  logic [15:0] pulse_spacing_i,
    input  logic        pulse_en_i,
    input  logic        arm_i,
    input  logic        abort_i,
    input  logic        trigger_i,
    input  logic        reset_en_i,
    input  logic [15:0] reset_length_i,
    output logic        glitch_o,
    output logic        target_reset_o,
    output logic        armed_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_PULSE,
        S_SPACE
    } state_t;

    state_t      state_reg, state_next;
    logic [15:0] timer_reg, timer_next;
    logic [7:0]  pulses_reg, pulses_next;
    logic [7:0]  width_reg, width_next;
    logic [15:0] space_reg, space_next;
    logic        done_next;
    logic        launch;

    logic        glitch_reg, armed_reg, busy_reg, done_reg;
    logic [15:0] rcnt_reg, rcnt_next;
    logic        target_reset_reg;

    logic        trig_level;
    logic        trig_hist_reg;
    logic        trig_rise;

    logic [7:0]  width_clamp;
    logic [7:0]  pulses_clamp;
    logic [15:0] space_clamp;

`ifdef GLITCH_TRIGGER_SYNC_EN
    logic [1:0] trig_sync_reg;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_sync
            always_ff @(posedge clk) begin
                if (rst) begin
                    trig_sync_reg[gi] <= 1'b0;
                end else if (gi == 0) begin
                    trig_sync_reg[gi] <= trigger_i;
                end else begin
                    trig_sync_reg[gi] <= trig_sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign trig_level = trig_sync_reg[1];
`else
    assign trig_level = trigger_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_hist_reg <= 1'b0;
        end else begin
            trig_hist_reg <= trig_level;
        end
    end

    // Edges arriving while the target is held in reset are discarded, not deferred.
    assign trig_rise = trig_level & ~trig_hist_reg & ~target_reset_reg;

    assign width_clamp  = (width_i == 8'd0)         ? 8'd1  : width_i;
    assign pulses_clamp = (num_pulses_i == 8'd0)    ? 8'd1  : num_pulses_i;
    assign space_clamp  = (pulse_spacing_i == 16'd0) ? 16'd1 : pulse_spacing_i;

    always_comb begin
        state_next  = state_reg;
        timer_next  = timer_reg;
        pulses_next = pulses_reg;
        width_next  = width_reg;
        space_next  = space_reg;
        done_next   = 1'b0;
        launch      = 1'b0;

        if (abort_i) begin
            state_next  = S_IDLE;
            timer_next  = 16'd0;
            pulses_next = 8'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (pulse_en_i) begin
                        launch = 1'b1;
                    end else if (arm_i) begin
                        state_next = S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (pulse_en_i || trig_rise) begin
                        launch = 1'b1;
                    end
                end
                S_DELAY: begin
                    if (timer_reg == 16'd1) begin
                        state_next = S_PULSE;
                        timer_next = {8'd0, width_reg};
                    end else begin
                        timer_next = timer_reg - 16'd1;
                    end
                end
                S_PULSE: begin
                    if (timer_reg == 16'd1) begin
                        pulses_next = pulses_reg - 8'd1;
                        if (pulses_reg == 8'd1) begin
                            state_next = S_IDLE;
                            timer_next = 16'd0;
                            done_next  = 1'b1;
                        end else begin
                            state_next = S_SPACE;
                            timer_next = space_reg;
                        end
                    end else begin
                        timer_next = timer_reg - 16'd1;
                    end
                end
                S_SPACE: begin
                    if (timer_reg == 16'd1) begin
                        state_next = S_PULSE;
                        timer_next = {8'd0, width_reg};
                    end else begin
                        timer_next = timer_reg - 16'd1;
                    end
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase

            // Snapshot the configuration; later input changes cannot disturb the train.
            if (launch) begin
                width_next  = width_clamp;
                space_next  = space_clamp;
                pulses_next = pulses_clamp;
                if (delay_i == 16'd0) begin
                    state_next = S_PULSE;
                    timer_next = {8'd0, width_clamp};
                end else begin
                    state_next = S_DELAY;
                    timer_next = delay_i;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            timer_reg  <= 16'd0;
            pulses_reg <= 8'd0;
            width_reg  <= 8'd0;
            space_reg  <= 16'd0;
            glitch_reg <= 1'b0;
            armed_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            timer_reg  <= timer_next;
            pulses_reg <= pulses_next;
            width_reg  <= width_next;
            space_reg  <= space_next;
            glitch_reg <= (state_next == S_PULSE);
            armed_reg  <= (state_next == S_ARMED);
            busy_reg   <= (state_next == S_DELAY) || (state_next == S_PULSE) ||
                          (state_next == S_SPACE);
            done_reg   <= done_next;
        end
    end

    // Target reset counter runs on its own; a new strobe always reloads the full length.
    always_comb begin
        rcnt_next = rcnt_reg;
        if (reset_en_i) begin
            rcnt_next = reset_length_i;
        end else if (rcnt_reg != 16'd0) begin
            rcnt_next = rcnt_reg - 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt_reg         <= 16'd0;
            target_reset_reg <= 1'b0;
        end else begin
            rcnt_reg         <= rcnt_next;
            target_reset_reg <= (rcnt_next != 16'd0);
        end
    end

    assign glitch_o       = glitch_reg;
    assign target_reset_o = target_reset_reg;
    assign armed_o        = armed_reg;
    assign busy_o         = busy_reg;
    assign done_o         = done_reg;

endmodule
